battery_indicator: RTL and testbench
====================================

// Module: battery_indicator
// PURPOSE
//   Drives the red/green status LEDs of the battery pack from charger, USB, button and level inputs.
//   - Reports battery level on button press when unplugged.
//   - Reports charge state while plugged in.
//   - Detects the charger STAT fault blink pattern and flashes red.
//   Sits between the charger IC / comparator pins and the LED drivers.
// PARAMETERS
//   FAULT_WINDOW  8192  clk cycles with no STAT edge before a fault is cleared (~1.6 s at 5 kHz)
//   BLINK_HALF    1024  clk cycles per half-period of the red fault blink
// PORTS
//   clk     in   1  system clock (5 kHz nominal)
//   rst     in   1  synchronous reset, active-high
//   level   in   1  1 = battery full, 0 = not full
//   button  in   1  1 = pressed, 0 = released
//   usb     in   1  1 = USB plugged in
//   stat    in   1  charger STAT pin: 0 = charging, 1 = not charging, toggling = fault
//   pos     in   1  comparator: voltage above 2.0 V threshold
//   neg     in   1  comparator: voltage below 1.0 V threshold
//   red     out  1  red LED, 1 = on
//   green   out  1  green LED, 1 = on
// BEHAVIOUR
//   Reset (rst=1 at posedge clk):
//   - red=0, green=0; synchronisers, counters and the fault flag are cleared.
//   Input synchronisation:
//   - All six inputs pass through 2-flop synchronisers.
//   - LEDs are registered.
//   - Latency from input change to LED change: 3 clk cycles.
//   Fault detection:
//   - Any edge on synchronised stat while usb=1 sets fault and reloads the FAULT_WINDOW counter.
//   - fault clears when the counter expires with no further stat edge, or immediately when usb=0.
//   - A single stat edge from a normal charge->done transition also sets fault.
//   - That fault self-clears after FAULT_WINDOW cycles; steady-state output then applies.
//   LED priority, highest first:
//   1. fault=1: green=0; red blinks, starting on.
//      - red toggles every BLINK_HALF cycles; the phase counter restarts on fault entry.
//      - button, level, pos and neg are ignored.
//   2. usb=1, stat=1 (charge done): green=1, red=0, regardless of button, level, pos and neg.
//   3. usb=1, stat=0 (charging):
//      - neg=1 & pos=0: red=1, green=1.
//      - otherwise: red=0, green=0.
//      - button and level are ignored.
//   4. usb=0:
//      - button=1, level=1: green=1, red=0.
//      - button=1, level=0: red=1, green=0.
//      - button=0: both off.
//      - stat, pos and neg are ignored.
//   Boundary conditions:
//   - The blink counter wraps modulo BLINK_HALF.
//   - The window counter saturates at 0.
//   - Reset asserted mid-fault returns to the reset state on the next clock edge.
// TESTING
//   1. usb=0, level=0: button 0->1->0 -> red 0->1->0 (3-cycle latency), green=0 throughout.
//   2. usb=0, level=1, button=1 -> green=1, red=0.
//      Same with pos=0, neg=1 -> unchanged.
//   3. usb=1, stat=0:
//      - pos=1, neg=0 -> both off.
//      - pos=0, neg=1 -> both on.
//      - pos=0, neg=0 -> both off.
//   4. usb=1, stat=1, level=1, button any -> green=1, red=0 steady, after the post-transition fault window expires.
//   5. usb=1, stat toggled every 500 cycles for 20 toggles:
//      - red blinks with period 2*BLINK_HALF, green=0.
//      - Stop toggling (stat=1) -> after FAULT_WINDOW+3 cycles green=1, red=0.
//   6. Assert rst=1 mid-fault for 1 cycle -> red=0, green=0 on the next edge.
//      - Outputs then follow the priority rules from scratch.

Source files
------------

// File: rtl/battery_indicator.sv
// Battery pack status LED driver: level report on button press, charge state on USB,
// and a blinking red indication when the charger STAT pin toggles (fault).
module battery_indicator #(
    parameter int unsigned FAULT_WINDOW = 8192,
    parameter int unsigned BLINK_HALF   = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic level,
    input  logic button,
    input  logic usb,
    input  logic stat,
    input  logic pos,
    input  logic neg,
    output logic red,
    output logic green
);

    localparam int unsigned WW = $clog2(FAULT_WINDOW + 1);
    localparam int unsigned BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [WW-1:0] WinLoad   = WW'(FAULT_WINDOW - 1);
    localparam logic [BW-1:0] BlinkLast = BW'(BLINK_HALF - 1);

    logic [5:0]    sync1_q, sync2_q;
    logic          level_s, button_s, usb_s, stat_s, pos_s, neg_s;
    logic          stat_prev_q;
    logic          stat_edge;
    logic          fault_q, fault_d;
    logic [WW-1:0] window_q, window_d;
    logic [BW-1:0] blink_q, blink_d;
    logic          blink_on_q, blink_on_d;
    logic          red_q, red_d, green_q, green_d;

    assign {level_s, button_s, usb_s, stat_s, pos_s, neg_s} = sync2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            stat_prev_q <= 1'b0;
            fault_q     <= 1'b0;
            window_q    <= '0;
            blink_q     <= '0;
            blink_on_q  <= 1'b0;
            red_q       <= 1'b0;
            green_q     <= 1'b0;
        end else begin
            sync1_q     <= {level, button, usb, stat, pos, neg};
            sync2_q     <= sync1_q;
            stat_prev_q <= stat_s;
            fault_q     <= fault_d;
            window_q    <= window_d;
            blink_q     <= blink_d;
            blink_on_q  <= blink_on_d;
            red_q       <= red_d;
            green_q     <= green_d;
        end
    end

    always_comb begin
        stat_edge  = usb_s & (stat_s ^ stat_prev_q);

        // Window counts down after each STAT edge and rests at zero.
        window_d = window_q;
        if (stat_edge) begin
            window_d = WinLoad;
        end else if (window_q != '0) begin
            window_d = window_q - 1'b1;
        end

        if (!usb_s) begin
            fault_d = 1'b0;
        end else if (stat_edge) begin
            fault_d = 1'b1;
        end else begin
            fault_d = fault_q && (window_q != '0);
        end

        // Blink phase restarts (red on) whenever a fault begins.
        blink_d    = blink_q;
        blink_on_d = blink_on_q;
        if (fault_d && !fault_q) begin
            blink_d    = '0;
            blink_on_d = 1'b1;
        end else if (fault_q) begin
            if (blink_q == BlinkLast) begin
                blink_d    = '0;
                blink_on_d = ~blink_on_q;
            end else begin
                blink_d = blink_q + 1'b1;
            end
        end

        // LED decision uses the next fault value so every path has the same latency.
        red_d   = 1'b0;
        green_d = 1'b0;
        if (fault_d) begin
            red_d = blink_on_d;
        end else if (usb_s) begin
            if (stat_s) begin
                green_d = 1'b1;
            end else if (neg_s && !pos_s) begin
                red_d   = 1'b1;
                green_d = 1'b1;
            end
        end else if (button_s) begin
            green_d = level_s;
            red_d   = ~level_s;
        end
    end

    assign red   = red_q;
    assign green = green_q;

endmodule

// File: tb/tb_battery_indicator.sv
// Directed self-checking bench for battery_indicator; LEDs compared as {red, green}.
module tb_battery_indicator;

    localparam int unsigned FW = 8192;
    localparam int unsigned BH = 1024;

    logic clk = 1'b0;
    logic rst, level, button, usb, stat, pos, neg;
    logic red, green;

    int n_checks = 0;
    int n_errors = 0;

    battery_indicator #(
        .FAULT_WINDOW (FW),
        .BLINK_HALF   (BH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .level  (level),
        .button (button),
        .usb    (usb),
        .stat   (stat),
        .pos    (pos),
        .neg    (neg),
        .red    (red),
        .green  (green)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: {red,green} got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    logic [1:0] exp_rg;

    initial begin
        rst = 1'b1; level = 0; button = 0; usb = 0; stat = 0; pos = 0; neg = 0;
        step(2);
        check("reset", {red, green}, 2'b00);
        rst = 1'b0;
        step(4);
        check("idle", {red, green}, 2'b00);

        // 1: unplugged, not full, button press/release with 3-cycle latency
        button = 1;
        step(2); check("press_lat2", {red, green}, 2'b00);
        step(1); check("press_lat3", {red, green}, 2'b10);
        button = 0;
        step(2); check("release_lat2", {red, green}, 2'b10);
        step(1); check("release_lat3", {red, green}, 2'b00);

        // 2: unplugged, full, pressed; comparators ignored
        level = 1; button = 1;
        step(3); check("full_press", {red, green}, 2'b01);
        neg = 1;
        step(3); check("full_press_neg", {red, green}, 2'b01);

        // 3: plugged, charging; button/level ignored
        usb = 1; stat = 0; pos = 1; neg = 0; level = 0;
        step(3); check("chg_pos", {red, green}, 2'b00);
        pos = 0; neg = 1;
        step(3); check("chg_low", {red, green}, 2'b11);
        neg = 0;
        step(3); check("chg_mid", {red, green}, 2'b00);

        // 4: charge done; the 0->1 transition raises a fault for one window
        level = 1; stat = 1;
        step(2); check("done_lat2", {red, green}, 2'b00);
        step(1); check("done_fault", {red, green}, 2'b10);
        step(FW - 1);
        check("done_window_end", {red, green}, 2'b00);
        step(1); check("done_steady", {red, green}, 2'b01);
        button = 0;
        step(3); check("done_nobutton", {red, green}, 2'b01);

        // 5: STAT toggling every 500 cycles, 20 toggles (ends at stat=1)
        begin
            int toggles = 0;
            for (int t = 0; t <= 9500 + FW + 5; t++) begin
                if ((t % 500) == 0 && toggles < 20) begin
                    stat = ~stat;
                    toggles++;
                end
                step(1);
                if (t + 1 < 3) exp_rg = 2'b01;
                else if (t + 1 <= 9502 + FW) exp_rg = {((((t + 1 - 3) / BH) % 2) == 0), 1'b0};
                else exp_rg = 2'b01;
                check("blink", {red, green}, exp_rg);
            end
        end

        // 6: reset mid-fault, then restart from scratch
        stat = 0; neg = 1; pos = 0;
        step(13);
        check("fault_again", {red, green}, 2'b10);
        rst = 1;
        step(1); check("rst_mid_fault", {red, green}, 2'b00);
        rst = 0;
        step(2); check("after_rst_lat2", {red, green}, 2'b00);
        step(1); check("after_rst_chg_low", {red, green}, 2'b11);
        step(20); check("after_rst_no_fault", {red, green}, 2'b11);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
